// File: rtl/flag_eval_pipe_if.sv
// Operand, pipeline-control and result signals of the compare/condition unit.
// The master side is the execute-stage producer/consumer; the slave side is flag_eval_pipe.
interface flag_eval_pipe_if #(
   parameter int WIDTH = 16
) ();
   logic             in_valid;
   logic [2:0]       CmpOp;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             stall;
   logic             flush;
   logic             err_clr;
   logic             out_valid;
   logic             CmpOut;
   logic             Zero;
   logic             Neg;
   logic             Ofl;
   logic             err;
   logic             err_sticky;

   modport master (
      output in_valid, CmpOp, A, B, stall, flush, err_clr,
      input  out_valid, CmpOut, Zero, Neg, Ofl, err, err_sticky
   );

   modport slave (
      input  in_valid, CmpOp, A, B, stall, flush, err_clr,
      output out_valid, CmpOut, Zero, Neg, Ofl, err, err_sticky
   );
endinterface

// File: rtl/flag_eval_pipe.sv
// Two-stage compare/condition unit: S1 registers operands, S2 registers A-B flags,
// the resolved compare bit and an illegal-op error, with stall/flush and a sticky error.
module flag_eval_pipe #(
   parameter int WIDTH = 16
) (
   input logic              clk,
   input logic              rst,
   flag_eval_pipe_if.slave  bus
);
   localparam int MSB = WIDTH - 1;

   localparam logic [2:0] OP_EQ  = 3'b000;
   localparam logic [2:0] OP_LT  = 3'b001;
   localparam logic [2:0] OP_LE  = 3'b010;
   localparam logic [2:0] OP_CO  = 3'b011;
   localparam logic [2:0] OP_LTU = 3'b100;
   localparam logic [2:0] OP_NE  = 3'b101;

   logic             s1_valid_r;
   logic [2:0]       s1_op_r;
   logic [WIDTH-1:0] s1_a_r;
   logic [WIDTH-1:0] s1_b_r;

   logic             out_valid_r;
   logic             cmpout_r;
   logic             zero_r;
   logic             neg_r;
   logic             ofl_r;
   logic             err_r;
   logic             err_sticky_r;

   logic [WIDTH:0]   d_s;
   logic [WIDTH:0]   s_s;
   logic             zero_s;
   logic             neg_s;
   logic             ofl_s;
   logic             lt_s;
   logic             cmp_s;
   logic             illegal_s;
   logic             retire_err_s;

   // Flags of A-B and the compare result for the operation held in S1
   always_comb begin
      d_s       = {1'b0, s1_a_r} + {1'b0, ~s1_b_r} + {{WIDTH{1'b0}}, 1'b1};
      s_s       = {1'b0, s1_a_r} + {1'b0, s1_b_r};
      zero_s    = (d_s[MSB:0] == {WIDTH{1'b0}});
      neg_s     = d_s[MSB];
      ofl_s     = (s1_a_r[MSB] != s1_b_r[MSB]) & (d_s[MSB] != s1_a_r[MSB]);
      lt_s      = neg_s ^ ofl_s;
      cmp_s     = 1'b0;
      illegal_s = 1'b0;
      case (s1_op_r)
         OP_EQ:   cmp_s = zero_s;
         OP_LT:   cmp_s = lt_s;
         OP_LE:   cmp_s = lt_s | zero_s;
         OP_CO:   cmp_s = s_s[WIDTH];
         OP_LTU:  cmp_s = ~d_s[WIDTH];
         OP_NE:   cmp_s = ~zero_s;
         default: illegal_s = 1'b1;
      endcase
      retire_err_s = s1_valid_r & illegal_s;
   end

   // Pipeline registers and sticky error; priority rst > flush > stall > advance
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_valid_r   <= 1'b0;
         s1_op_r      <= 3'b000;
         s1_a_r       <= {WIDTH{1'b0}};
         s1_b_r       <= {WIDTH{1'b0}};
         out_valid_r  <= 1'b0;
         cmpout_r     <= 1'b0;
         zero_r       <= 1'b0;
         neg_r        <= 1'b0;
         ofl_r        <= 1'b0;
         err_r        <= 1'b0;
         err_sticky_r <= 1'b0;
      end else if (bus.flush) begin
         // Data fields are left as-is; only the valid/error qualifiers are killed
         s1_valid_r   <= 1'b0;
         out_valid_r  <= 1'b0;
         err_r        <= 1'b0;
         err_sticky_r <= err_sticky_r & ~bus.err_clr;
      end else if (bus.stall) begin
         err_sticky_r <= err_sticky_r & ~bus.err_clr;
      end else begin
         s1_valid_r   <= bus.in_valid;
         s1_op_r      <= bus.CmpOp;
         s1_a_r       <= bus.A;
         s1_b_r       <= bus.B;
         out_valid_r  <= s1_valid_r;
         cmpout_r     <= cmp_s;
         zero_r       <= zero_s;
         neg_r        <= neg_s;
         ofl_r        <= ofl_s;
         err_r        <= retire_err_s;
         err_sticky_r <= retire_err_s | (err_sticky_r & ~bus.err_clr);
      end
   end

   assign bus.out_valid  = out_valid_r;
   assign bus.CmpOut     = cmpout_r;
   assign bus.Zero       = zero_r;
   assign bus.Neg        = neg_r;
   assign bus.Ofl        = ofl_r;
   assign bus.err        = err_r;
   assign bus.err_sticky = err_sticky_r;
endmodule

// File: tb/tb_flag_eval_pipe.sv
// Bench for flag_eval_pipe: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an arithmetic reference model.
module tb_flag_eval_pipe;
   localparam int W = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   flag_eval_pipe_if #(.WIDTH(W)) bus ();
   flag_eval_pipe #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus));

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Reference: {cmp, zero, neg, ofl, err} from true integer arithmetic
   function automatic logic [4:0] ref_eval(input logic [2:0] op, input logic [W-1:0] a,
                                           input logic [W-1:0] b);
      longint sa, sb, sd, ua, ub, lim;
      logic [W-1:0] diff;
      logic c, z, n, o, e;
      sa   = longint'($signed(a));
      sb   = longint'($signed(b));
      ua   = longint'(a);
      ub   = longint'(b);
      sd   = sa - sb;
      lim  = longint'(1) << (W - 1);
      diff = a - b;
      z    = (a == b);
      n    = diff[W-1];
      o    = (sd > lim - 1) || (sd < -lim);
      e    = 1'b0;
      case (op)
         3'd0:    c = z;
         3'd1:    c = (sa < sb);
         3'd2:    c = (sa <= sb);
         3'd3:    c = ((ua + ub) >= (longint'(1) << W));
         3'd4:    c = (ua < ub);
         3'd5:    c = !z;
         default: begin c = 1'b0; e = 1'b1; end
      endcase
      return {c, z, n, o, e};
   endfunction

   logic         m1_v;
   logic [2:0]   m1_op;
   logic [W-1:0] m1_a, m1_b;
   logic         e_v, e_cmp, e_z, e_n, e_o, e_err, e_st;
   logic [4:0]   m_r;
   assign m_r = ref_eval(m1_op, m1_a, m1_b);

   // Reference pipeline: one slot of queued input, one slot of expected outputs
   always @(posedge clk) begin
      if (rst) begin
         m1_v <= 1'b0; e_v <= 1'b0; e_err <= 1'b0; e_st <= 1'b0;
         e_cmp <= 1'b0; e_z <= 1'b0; e_n <= 1'b0; e_o <= 1'b0;
      end else if (bus.flush) begin
         m1_v <= 1'b0; e_v <= 1'b0; e_err <= 1'b0;
         e_st <= e_st & ~bus.err_clr;
      end else if (bus.stall) begin
         e_st <= e_st & ~bus.err_clr;
      end else begin
         m1_v  <= bus.in_valid; m1_op <= bus.CmpOp; m1_a <= bus.A; m1_b <= bus.B;
         e_v   <= m1_v;
         e_cmp <= m_r[4]; e_z <= m_r[3]; e_n <= m_r[2]; e_o <= m_r[1];
         e_err <= m1_v & m_r[0];
         e_st  <= (m1_v & m_r[0]) | (e_st & ~bus.err_clr);
      end
   end

   // Every-cycle comparison against the reference
   always @(negedge clk) begin
      if (chk_en) begin
         check("m_out_valid", bus.out_valid, e_v);
         check("m_err", bus.err, e_err);
         check("m_err_sticky", bus.err_sticky, e_st);
         if (e_v) begin
            check("m_CmpOut", bus.CmpOut, e_cmp);
            check("m_Zero", bus.Zero, e_z);
            check("m_Neg", bus.Neg, e_n);
            check("m_Ofl", bus.Ofl, e_o);
         end
      end
   end

   task automatic drive(input logic v, input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b);
      bus.in_valid = v;
      bus.CmpOp    = op;
      bus.A        = a;
      bus.B        = b;
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rand_opnd();
      case ($urandom_range(0, 7))
         0:       return {W{1'b0}};
         1:       return {1'b1, {(W-1){1'b0}}};
         2:       return {1'b0, {(W-1){1'b1}}};
         3:       return {W{1'b1}};
         4:       return {{(W-1){1'b0}}, 1'b1};
         default: return W'($urandom);
      endcase
   endfunction

   initial begin
      bus.stall = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0;
      // Reset held two cycles with valid input presented
      rst = 1'b1;
      drive(1'b1, 3'b001, 16'h1234, 16'h0042);
      tick(); tick();
      check("rst_out_valid", bus.out_valid, 1'b0);
      check("rst_CmpOut", bus.CmpOut, 1'b0);
      check("rst_Zero", bus.Zero, 1'b0);
      check("rst_Neg", bus.Neg, 1'b0);
      check("rst_Ofl", bus.Ofl, 1'b0);
      check("rst_err", bus.err, 1'b0);
      check("rst_err_sticky", bus.err_sticky, 1'b0);
      chk_en = 1'b1;

      // First result exactly two edges after the first valid sample
      rst = 1'b0;
      drive(1'b1, 3'b000, 16'h0001, 16'h0001);
      tick();
      check("lat_edge1_valid", bus.out_valid, 1'b0);
      drive(1'b0, 3'b000, 16'h0000, 16'h0000);
      tick();
      check("lat_edge2_valid", bus.out_valid, 1'b1);
      check("lat_edge2_cmp", bus.CmpOut, 1'b1);

      // Signed overflow: 0x8000 - 1
      drive(1'b1, 3'b001, 16'h8000, 16'h0001);
      tick();
      drive(1'b1, 3'b100, 16'h8000, 16'h0001);
      tick();
      check("ofl_lt_cmp", bus.CmpOut, 1'b1);
      check("ofl_lt_neg", bus.Neg, 1'b0);
      check("ofl_lt_ofl", bus.Ofl, 1'b1);
      drive(1'b0, 3'b000, 16'h0000, 16'h0000);
      tick();
      check("ofl_ltu_cmp", bus.CmpOut, 1'b0);
      check("ofl_ltu_valid", bus.out_valid, 1'b1);

      // Mixed ops back to back
      drive(1'b1, 3'b000, 16'd5, 16'd5);       tick();
      drive(1'b1, 3'b101, 16'd5, 16'd5);       tick();
      check("mix_eq", bus.CmpOut, 1'b1);
      drive(1'b1, 3'b010, 16'hFFFD, 16'd2);    tick();
      check("mix_ne", bus.CmpOut, 1'b0);
      drive(1'b1, 3'b011, 16'hFFFF, 16'd1);    tick();
      check("mix_le", bus.CmpOut, 1'b1);
      drive(1'b0, 3'b000, 16'h0000, 16'h0000); tick();
      check("mix_co", bus.CmpOut, 1'b1);
      check("mix_co_valid", bus.out_valid, 1'b1);

      // Stall with both stages full; changed inputs must not be captured
      drive(1'b1, 3'b000, 16'd7, 16'd7); tick();
      drive(1'b1, 3'b101, 16'd7, 16'd7); tick();
      bus.stall = 1'b1;
      drive(1'b1, 3'b100, 16'd1, 16'd2);
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_valid", bus.out_valid, 1'b1);
         check("stall_cmp", bus.CmpOut, 1'b1);
         check("stall_zero", bus.Zero, 1'b1);
      end
      bus.stall = 1'b0;
      drive(1'b0, 3'b000, 16'h0000, 16'h0000);
      tick();
      check("stall_resume_valid", bus.out_valid, 1'b1);
      check("stall_resume_cmp", bus.CmpOut, 1'b0);
      tick();
      check("stall_no_capture", bus.out_valid, 1'b0);

      // Flush with stall, illegal op in flight and a same-cycle input
      drive(1'b1, 3'b000, 16'd9, 16'd9); tick();
      drive(1'b1, 3'b110, 16'd9, 16'd9); tick();
      bus.flush = 1'b1; bus.stall = 1'b1;
      drive(1'b1, 3'b000, 16'd3, 16'd3);
      tick();
      check("flush_valid", bus.out_valid, 1'b0);
      check("flush_err", bus.err, 1'b0);
      check("flush_sticky", bus.err_sticky, 1'b0);
      bus.flush = 1'b0; bus.stall = 1'b0;
      drive(1'b0, 3'b000, 16'h0000, 16'h0000);
      tick();
      check("flush_input_lost", bus.out_valid, 1'b0);

      // Illegal op and sticky error behaviour
      drive(1'b1, 3'b110, 16'd5, 16'd3); tick();
      drive(1'b0, 3'b000, 16'h0000, 16'h0000); tick();
      check("ill_valid", bus.out_valid, 1'b1);
      check("ill_err", bus.err, 1'b1);
      check("ill_cmp", bus.CmpOut, 1'b0);
      check("ill_sticky", bus.err_sticky, 1'b1);
      tick();
      check("ill_sticky_hold", bus.err_sticky, 1'b1);
      check("ill_bubble_err", bus.err, 1'b0);
      drive(1'b1, 3'b111, 16'd1, 16'd2); tick();
      drive(1'b0, 3'b000, 16'h0000, 16'h0000);
      bus.err_clr = 1'b1;
      tick();
      check("clr_vs_set_err", bus.err, 1'b1);
      check("clr_vs_set_sticky", bus.err_sticky, 1'b1);
      tick();
      check("clr_sticky", bus.err_sticky, 1'b0);
      bus.err_clr = 1'b0;

      // Randomized traffic against the reference model
      for (int i = 0; i < 3000; i++) begin
         logic [W-1:0] ra;
         logic [W-1:0] rb;
         ra = rand_opnd();
         rb = ($urandom_range(0, 5) == 0) ? ra : rand_opnd();
         drive(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), ra, rb);
         bus.stall   = ($urandom_range(0, 6) == 0);
         bus.flush   = ($urandom_range(0, 19) == 0);
         bus.err_clr = ($urandom_range(0, 15) == 0);
         rst         = ($urandom_range(0, 199) == 0);
         tick();
      end
      rst = 1'b0; bus.stall = 1'b0; bus.flush = 1'b0; bus.err_clr = 1'b0;
      drive(1'b0, 3'b000, 16'h0000, 16'h0000);
      tick(); tick(); tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
